// File: rtl/writeback_unit.sv
// Register-file write port: merges ALU results and in-order load responses.
// Optional WB_BYPASS_EN adds forwarding ports and drops the write-port hazard term.
module writeback_unit #(
  parameter int LD_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic            hazard,
  output logic            reg_wr,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
`ifdef WB_BYPASS_EN
  output logic            fwd1_valid,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
`endif
  output logic            err
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      rd_q  [LD_DEPTH];
  logic [2:0]      f3_q  [LD_DEPTH];
  logic [1:0]      off_q [LD_DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            empty, push, pop;
  logic            hit1, hit2;
  logic [PW-1:0]   rel;

  function automatic logic [XLEN-1:0] extend(
    input logic [XLEN-1:0] w,
    input logic [2:0]      f3,
    input logic [1:0]      off
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    unique case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign empty     = (cnt_q == '0);
  assign ld_ready  = (cnt_q != CW'(LD_DEPTH));
  assign alu_ready = !mem_rvalid;
  assign push      = ld_issue && ld_ready;
  assign pop       = mem_rvalid && !empty;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (mem_rvalid) begin
      if (!empty) begin
        wr_d    = (rd_q[rp_q] != 5'd0);
        waddr_d = rd_q[rp_q];
        wdata_d = extend(mem_rdata, f3_q[rp_q], off_q[rp_q]);
      end else begin
        err_d = 1'b1;
      end
    end else if (alu_valid) begin
      wr_d    = (alu_rd != 5'd0);
      waddr_d = alu_rd;
      wdata_d = alu_data;
    end
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    rel  = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      rel = PW'(i) - rp_q;
      if ({1'b0, rel} < cnt_q) begin
        if (rd_q[i] == raddr1) hit1 = 1'b1;
        if (rd_q[i] == raddr2) hit2 = 1'b1;
      end
    end
`ifndef WB_BYPASS_EN
    if (wr_q && waddr_q == raddr1) hit1 = 1'b1;
    if (wr_q && waddr_q == raddr2) hit2 = 1'b1;
`endif
    hazard = (hit1 && raddr1 != 5'd0) ||
             (hit2 && raddr2 != 5'd0);
  end

`ifdef WB_BYPASS_EN
  assign fwd1_valid = wr_q && waddr_q == raddr1 && raddr1 != 5'd0;
  assign fwd2_valid = wr_q && waddr_q == raddr2 && raddr2 != 5'd0;
  assign fwd1_data  = wdata_q;
  assign fwd2_data  = wdata_q;
`endif

  always_ff @(posedge clock) begin
    if (push) begin
      rd_q[wp_q]  <= ld_rd;
      f3_q[wp_q]  <= ld_funct3;
      off_q[wp_q] <= ld_offset;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_q + PW'(push);
      rp_q    <= rp_q + PW'(pop);
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign reg_wr = wr_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign err    = err_q;

endmodule
